// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state encodings,
// instruction word field layout and the default HALT opcode.
package instr_fetch_pkg;

   localparam int unsigned INS_W    = 16;
   localparam int unsigned OPCODE_W = 4;

   // Fetch sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_LOAD = 2'd2,
      ST_EXEC = 2'd3
   } state_t;

   // Instruction word layout: opcode 15:12, DR 11:8, SA 7:4, SB 3:0
   typedef struct packed {
      logic [3:0] opcode;
      logic [3:0] dr;
      logic [3:0] sa;
      logic [3:0] sb;
   } insn_t;

   localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEF = 4'hF;

   // Extract the opcode field from a raw instruction word
   function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INS_W-1:0] word);
      insn_t insn;
      insn = insn_t'(word);
      return insn.opcode;
   endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// PC register for the fetch sequencer.
// Ports: clk, reset (sync, active-high), inc_en (pc+1, wraps), load_en (pc<=load_val,
// has priority over inc_en), load_val, pc.
module instr_fetch_pc_reg #(
   parameter int unsigned PC_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            inc_en,
   input  logic            load_en,
   input  logic [PC_W-1:0] load_val,
   output logic [PC_W-1:0] pc
);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= '0;
      end else if (load_en) begin
         pc <= load_val;
      end else if (inc_en) begin
         pc <= pc + PC_W'(1);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: holds the PC, reads instruction words from program
// memory over a req/ack handshake, presents them on ins with a one-cycle IL strobe,
// then waits for ex_done (optionally with a jump) before the next fetch. HALT
// opcode returns to IDLE after its load.
// Ports: clk_main, reset (sync, active-high), start; mem_req/mem_addr/mem_rdata/mem_ack
// memory read port; ins/IL instruction register load; ex_done/pc_load/pc_target from
// the datapath; pc, busy, fetch_err status.
// Optional: IFETCH_TIMEOUT_EN adds a TIMEOUT_CYC-cycle mem_ack watchdog driving the
// sticky fetch_err flag; without it REQ waits indefinitely and fetch_err is 0.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int unsigned          PC_W        = 8,
   parameter logic [OPCODE_W-1:0]  HALT_OPCODE = HALT_OPCODE_DEF
`ifdef IFETCH_TIMEOUT_EN
   ,
   parameter int unsigned          TIMEOUT_CYC = 16
`endif
) (
   input  logic             clk_main,
   input  logic             reset,
   input  logic             start,
   output logic             mem_req,
   output logic [PC_W-1:0]  mem_addr,
   input  logic [INS_W-1:0] mem_rdata,
   input  logic             mem_ack,
   output logic [INS_W-1:0] ins,
   output logic             IL,
   input  logic             ex_done,
   input  logic             pc_load,
   input  logic [PC_W-1:0]  pc_target,
   output logic [PC_W-1:0]  pc,
   output logic             busy,
   output logic             fetch_err
);

   state_t state;
   logic   pc_inc;
   logic   pc_jump;

`ifdef IFETCH_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] to_cnt;
`endif

   // PC advances in LOAD; jump only when the datapath completes in EXEC
   assign pc_inc  = (state == ST_LOAD);
   assign pc_jump = (state == ST_EXEC) && ex_done && pc_load;

   instr_fetch_pc_reg #(
      .PC_W (PC_W)
   ) u_pc_reg (
      .clk      (clk_main),
      .reset    (reset),
      .inc_en   (pc_inc),
      .load_en  (pc_jump),
      .load_val (pc_target),
      .pc       (pc)
   );

   // pc is already a register, so the address is stable for the whole REQ phase
   assign mem_addr = pc;

   // Fetch FSM; outputs are registered alongside the state transitions
   always_ff @(posedge clk_main) begin
      if (reset) begin
         state   <= ST_IDLE;
         ins     <= '0;
         IL      <= 1'b0;
         mem_req <= 1'b0;
         busy    <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
         fetch_err <= 1'b0;
         to_cnt    <= '0;
`endif
      end else begin
         IL <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_REQ;
                  mem_req <= 1'b1;
                  busy    <= 1'b1;
`ifdef IFETCH_TIMEOUT_EN
                  fetch_err <= 1'b0;
                  to_cnt    <= '0;
`endif
               end
            end
            ST_REQ: begin
               if (mem_ack) begin
                  ins     <= mem_rdata;
                  IL      <= 1'b1;
                  mem_req <= 1'b0;
                  state   <= ST_LOAD;
               end
`ifdef IFETCH_TIMEOUT_EN
               else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                  mem_req   <= 1'b0;
                  busy      <= 1'b0;
                  fetch_err <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
`endif
            end
            ST_LOAD: begin
               // ins was captured on entry to LOAD, so its opcode is valid here
               if (opcode_of(ins) == HALT_OPCODE) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (ex_done) begin
                  state   <= ST_REQ;
                  mem_req <= 1'b1;
`ifdef IFETCH_TIMEOUT_EN
                  to_cnt  <= '0;
`endif
               end
            end
            default: begin
               state   <= ST_IDLE;
               mem_req <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

`ifndef IFETCH_TIMEOUT_EN
   assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: basic fetch, sequential fetches, jumps, HALT,
// PC wrap, reset during REQ and (when IFETCH_TIMEOUT_EN is defined) the ack watchdog.
module tb_instr_fetch;

   logic        clk_main = 1'b0;
   logic        reset;
   logic        start;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic [15:0] ins;
   logic        IL;
   logic        ex_done;
   logic        pc_load;
   logic [7:0]  pc_target;
   logic [7:0]  pc;
   logic        busy;
   logic        fetch_err;

   int checks   = 0;
   int failures = 0;
   int il_cnt   = 0;
   int il_dbl   = 0;
   logic il_prev = 1'b0;

   instr_fetch dut (
      .clk_main  (clk_main),
      .reset     (reset),
      .start     (start),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .ins       (ins),
      .IL        (IL),
      .ex_done   (ex_done),
      .pc_load   (pc_load),
      .pc_target (pc_target),
      .pc        (pc),
      .busy      (busy),
      .fetch_err (fetch_err)
   );

   always #5 clk_main = ~clk_main;

   // IL pulse counter and back-to-back detector
   always @(negedge clk_main) begin
      if (IL) il_cnt++;
      if (IL && il_prev) il_dbl++;
      il_prev = IL;
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_main);
      #1;
   endtask

   // Wait (bounded) for mem_req, hold ack off for dly cycles, then return word
   task automatic fetch(input logic [15:0] word, input int dly, output logic [7:0] addr);
      int n = 0;
      while (!mem_req && n < 50) begin
         tick();
         n++;
      end
      chk("req_seen", 16'(mem_req), 16'h1);
      addr = mem_addr;
      repeat (dly) tick();
      mem_ack   = 1'b1;
      mem_rdata = word;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 16'h0;
      chk("il_on_load", 16'(IL), 16'h1);
      chk("ins_on_load", ins, word);
   endtask

   // Pulse ex_done for one cycle, optionally with a jump
   task automatic finish_exec(input logic jmp, input logic [7:0] tgt);
      ex_done   = 1'b1;
      pc_load   = jmp;
      pc_target = tgt;
      tick();
      ex_done   = 1'b0;
      pc_load   = 1'b0;
      pc_target = 8'h00;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] a;
      int il0;
      int reqs;
      reset = 1'b1; start = 1'b0; mem_rdata = 16'h0; mem_ack = 1'b0;
      ex_done = 1'b0; pc_load = 1'b0; pc_target = 8'h00;
      do_reset();

      // Reset values
      chk("rst_mem_req", 16'(mem_req), 16'h0);
      chk("rst_il", 16'(IL), 16'h0);
      chk("rst_ins", ins, 16'h0000);
      chk("rst_pc", 16'(pc), 16'h0);
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_fetch_err", 16'(fetch_err), 16'h0);

      // Single fetch with 2-cycle ack delay
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_req_lat", 16'(mem_req), 16'h1);
      chk("start_busy", 16'(busy), 16'h1);
      fetch(16'h1234, 2, a);
      chk("t1_addr", 16'(a), 16'h0);
      tick();
      chk("t1_il_low", 16'(IL), 16'h0);
      chk("t1_pc", 16'(pc), 16'h1);
      chk("t1_ins_hold", ins, 16'h1234);

      // Three sequential words, ex_done 3 cycles after each IL
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      il0 = il_cnt;
      for (int i = 0; i < 3; i++) begin
         fetch(16'h1000 + 16'(i), 1, a);
         chk("seq_addr", 16'(a), 16'(i));
         tick();
         tick();
         if (i < 2) begin
            finish_exec(1'b0, 8'h00);
            chk("seq_req_after_done", 16'(mem_req), 16'h1);
         end
      end
      chk("seq_pc", 16'(pc), 16'h3);
      chk("seq_il_count", 16'(il_cnt - il0), 16'h3);

      // pc_load without ex_done is ignored
      pc_load   = 1'b1;
      pc_target = 8'h77;
      tick();
      pc_load   = 1'b0;
      tick();
      chk("noload_pc", 16'(pc), 16'h3);
      chk("noload_req", 16'(mem_req), 16'h0);
      chk("noload_busy", 16'(busy), 16'h1);

      // Jump on ex_done
      finish_exec(1'b1, 8'h40);
      chk("jump_req", 16'(mem_req), 16'h1);
      chk("jump_addr", 16'(mem_addr), 16'h40);

      // HALT: load then IDLE, no further requests, late ack ignored
      fetch(16'hF000, 0, a);
      chk("halt_addr", 16'(a), 16'h40);
      tick();
      chk("halt_busy", 16'(busy), 16'h0);
      chk("halt_pc", 16'(pc), 16'h41);
      mem_ack   = 1'b1;
      mem_rdata = 16'hBEEF;
      tick();
      mem_ack   = 1'b0;
      reqs = 0;
      for (int i = 0; i < 5; i++) begin
         if (mem_req) reqs++;
         tick();
      end
      chk("halt_no_req", 16'(reqs), 16'h0);
      chk("late_ack_ins", ins, 16'hF000);
      chk("late_ack_il", 16'(IL), 16'h0);

      // PC wrap: jump to 8'hFF, fetch a HALT there
      start = 1'b1;
      tick();
      start = 1'b0;
      fetch(16'h2000, 0, a);
      chk("wrap_pre_addr", 16'(a), 16'h41);
      tick();
      finish_exec(1'b1, 8'hFF);
      fetch(16'hF001, 0, a);
      chk("wrap_addr", 16'(a), 16'hFF);
      tick();
      chk("wrap_pc", 16'(pc), 16'h00);
      chk("wrap_idle", 16'(busy), 16'h0);

      // Reset while in REQ, then a stray ack one cycle later
      start = 1'b1;
      tick();
      start = 1'b0;
      fetch(16'h3000, 0, a);
      tick();
      finish_exec(1'b0, 8'h00);
      chk("mid_pre_req", 16'(mem_req), 16'h1);
      chk("mid_pre_pc", 16'(pc), 16'h1);
      reset = 1'b1;
      tick();
      reset     = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 16'h5555;
      tick();
      mem_ack   = 1'b0;
      chk("mid_rst_req", 16'(mem_req), 16'h0);
      chk("mid_rst_il", 16'(IL), 16'h0);
      chk("mid_rst_ins", ins, 16'h0000);
      chk("mid_rst_pc", 16'(pc), 16'h0);
      chk("mid_rst_busy", 16'(busy), 16'h0);

`ifdef IFETCH_TIMEOUT_EN
      // Withhold ack: REQ lasts 16 cycles, then IDLE with fetch_err set
      start = 1'b1;
      tick();
      start = 1'b0;
      reqs = 0;
      while (mem_req && reqs < 40) begin
         reqs++;
         tick();
      end
      chk("to_req_cycles", 16'(reqs), 16'd16);
      chk("to_err", 16'(fetch_err), 16'h1);
      chk("to_idle", 16'(busy), 16'h0);
      chk("to_pc", 16'(pc), 16'h0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("to_err_clr", 16'(fetch_err), 16'h0);
      do_reset();
`else
      chk("err_tied", 16'(fetch_err), 16'h0);
`endif

      chk("il_never_double", 16'(il_dbl), 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
